// File: rtl/packet_transmitter_if.sv
// ----------------------------------------------------------------------------
// packet_transmitter_if
//
// Purpose:
//   Groups the request, payload, flit-output and credit signals of the
//   packet transmitter into one bundle. The transmitter connects through the
//   master modport. The environment (request source, payload source, receiver
//   and credit return path) connects through the slave modport.
//
// Signal summary:
//   req_valid / req_ready        send-request handshake
//   req_to_addr                  destination address of the request
//   req_n_body                   number of body flits (0 = header only)
//   payload / payload_valid /    body data stream; a word is consumed on an
//   payload_ready                edge where valid and ready are both high
//   out_flit / out_flit_valid    registered flit output toward the receiver
//   credit_return                one downstream slot freed (pulse)
//   credits                      current credit count
//   busy                         a packet is in progress
//   err_len                      one-cycle pulse, request rejected for length
//   packets_sent                 wrapping count of completed packets
// ----------------------------------------------------------------------------
interface packet_transmitter_if #(
  parameter int FLIT_SIZE = 64,
  parameter int TO_W      = 8,
  parameter int LW        = 8,
  parameter int CREDITS   = 256,
  parameter int CNT_W     = $clog2(CREDITS) + 1
);

  logic                 req_valid;
  logic                 req_ready;
  logic [TO_W-1:0]      req_to_addr;
  logic [LW-1:0]        req_n_body;
  logic [FLIT_SIZE-1:0] payload;
  logic                 payload_valid;
  logic                 payload_ready;
  logic [FLIT_SIZE-1:0] out_flit;
  logic                 out_flit_valid;
  logic                 credit_return;
  logic [CNT_W-1:0]     credits;
  logic                 busy;
  logic                 err_len;
  logic [15:0]          packets_sent;

  // Transmitter side
  modport master (
    input  req_valid, req_to_addr, req_n_body,
    input  payload, payload_valid,
    input  credit_return,
    output req_ready, payload_ready,
    output out_flit, out_flit_valid,
    output credits, busy, err_len, packets_sent
  );

  // Environment side: request/payload source plus receiver credit path
  modport slave (
    output req_valid, req_to_addr, req_n_body,
    output payload, payload_valid,
    output credit_return,
    input  req_ready, payload_ready,
    input  out_flit, out_flit_valid,
    input  credits, busy, err_len, packets_sent
  );

endinterface

// File: rtl/packet_transmitter.sv
// ----------------------------------------------------------------------------
// packet_transmitter
//
// Purpose:
//   Source end of a flit link into a packet-buffer style receiver. A send
//   request (destination, body length) is turned into one header flit
//   followed by the body flits taken from the payload stream. The receiver
//   cannot push back, so every emitted flit spends one credit and the
//   receiver hands credits back with credit_return pulses.
//
// Ports:
//   clk   in  clock
//   rst   in  asynchronous reset, active high
//   tx    packet_transmitter_if.master (request, payload, flit output,
//         credit return, status counters)
// ----------------------------------------------------------------------------
module packet_transmitter #(
  parameter int FLIT_SIZE          = 64,
  parameter int NODE_ADDR          = 0,
  parameter int CREDITS            = 256,
  parameter int TO_ADDRESS_MSB     = 63,
  parameter int TO_ADDRESS_LSB     = 56,
  parameter int FROM_ADDRESS_MSB   = 55,
  parameter int FROM_ADDRESS_LSB   = 48,
  parameter int PACKET_LENGTH_MSB  = 47,
  parameter int PACKET_LENGTH_LSB  = 40
) (
  input logic                  clk,
  input logic                  rst,
  packet_transmitter_if.master tx
);

  localparam int TO_W   = TO_ADDRESS_MSB - TO_ADDRESS_LSB + 1;
  localparam int FROM_W = FROM_ADDRESS_MSB - FROM_ADDRESS_LSB + 1;
  localparam int LW     = PACKET_LENGTH_MSB - PACKET_LENGTH_LSB + 1;
  localparam int CNT_W  = $clog2(CREDITS) + 1;

  // The length field counts the header too, so the largest legal body is
  // one less than the largest encodable length: 2^LW - 2.
  localparam logic [LW-1:0]     MAX_BODY   = {{(LW-1){1'b1}}, 1'b0};
  localparam logic [FROM_W-1:0] NODE_FIELD = FROM_W'(NODE_ADDR);
  localparam logic [CNT_W-1:0]  CRED_FULL  = CNT_W'(CREDITS);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BODY
  } state_e;

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] header_q, header_d;
  logic [LW-1:0]        remaining_q, remaining_d;
  logic [FLIT_SIZE-1:0] out_flit_q, out_flit_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_W-1:0]     credits_q, credits_d;
  logic [15:0]          sent_q, sent_d;
  logic                 err_q, err_d;

  logic                 req_ready;
  logic                 payload_ready;
  logic                 req_fire;
  logic                 payload_fire;
  logic [FLIT_SIZE-1:0] new_header;

  // Handshake readiness. Both are forced low while reset is held so that
  // nothing is accepted during the asynchronous reset window.
  always_comb begin
    req_ready     = (state_q == IDLE) && !rst;
    payload_ready = (state_q == BODY) && (credits_q != '0) && !rst;
    req_fire      = tx.req_valid && req_ready;
    payload_fire  = tx.payload_valid && payload_ready;
  end

  // Header flit assembled from the request: destination, our own node
  // address and total length (body + header). All other bits stay zero.
  always_comb begin
    new_header = '0;
    new_header[TO_ADDRESS_MSB:TO_ADDRESS_LSB]       = tx.req_to_addr[TO_W-1:0];
    new_header[FROM_ADDRESS_MSB:FROM_ADDRESS_LSB]   = NODE_FIELD;
    new_header[PACKET_LENGTH_MSB:PACKET_LENGTH_LSB] = tx.req_n_body + LW'(1);
  end

  // Next-state logic. out_valid_d defaults low so a flit is flagged valid
  // for exactly one cycle; out_flit_d defaults to hold so the last flit
  // stays on the bus while idle or stalled.
  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    remaining_d = remaining_q;
    out_flit_d  = out_flit_q;
    out_valid_d = 1'b0;
    sent_d      = sent_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (tx.req_n_body > MAX_BODY) begin
            err_d = 1'b1;
          end else begin
            header_d    = new_header;
            remaining_d = tx.req_n_body;
            state_d     = HEADER;
          end
        end
      end

      HEADER: begin
        if (credits_q != '0) begin
          out_flit_d  = header_q;
          out_valid_d = 1'b1;
          if (remaining_q != '0) begin
            state_d = BODY;
          end else begin
            state_d = IDLE;
            sent_d  = sent_q + 16'd1;
          end
        end
      end

      BODY: begin
        if (payload_fire) begin
          out_flit_d  = tx.payload;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) begin
            state_d = IDLE;
            sent_d  = sent_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Credit accounting. An emission and a return on the same edge cancel.
  // A lone return while already full is dropped so the count saturates at
  // the downstream depth. The count cannot underflow because nothing is
  // emitted unless at least one credit is available.
  always_comb begin
    credits_d = credits_q;
    unique case ({out_valid_d, tx.credit_return})
      2'b10:   credits_d = credits_q - CNT_W'(1);
      2'b01:   if (credits_q != CRED_FULL) credits_d = credits_q + CNT_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  // State and datapath registers. Reset abandons any packet in flight and
  // restores the full credit pool; the receiver is expected to be reset
  // alongside so its buffer matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      header_q    <= '0;
      remaining_q <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      credits_q   <= CRED_FULL;
      sent_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      remaining_q <= remaining_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
      credits_q   <= credits_d;
      sent_q      <= sent_d;
      err_q       <= err_d;
    end
  end

  assign tx.req_ready      = req_ready;
  assign tx.payload_ready  = payload_ready;
  assign tx.out_flit       = out_flit_q;
  assign tx.out_flit_valid = out_valid_q;
  assign tx.credits        = credits_q;
  assign tx.busy           = (state_q != IDLE);
  assign tx.err_len        = err_q;
  assign tx.packets_sent   = sent_q;

endmodule

// File: tb/tb_packet_transmitter.sv
// ----------------------------------------------------------------------------
// tb_packet_transmitter
//
// Drives packet_transmitter (small credit pool, non-zero node address) with
// directed scenarios followed by a randomized phase. A transaction-level
// model tracks how many flits of the current packet are still owed, whether
// the header has gone out, the credit pool and the packet count, and
// predicts every output cycle by cycle.
// ----------------------------------------------------------------------------
module tb_packet_transmitter;

  localparam int FLIT    = 64;
  localparam int NODE    = 'h3C;
  localparam int CREDITS = 4;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          mLeft;
  bit          mHdrSent;
  logic [63:0] mHdr;
  logic [63:0] mFlit;
  bit          mValid;
  bit          mErr;
  int          mCred;
  int          mSent;

  packet_transmitter_if #(
    .FLIT_SIZE(FLIT), .TO_W(8), .LW(8), .CREDITS(CREDITS)
  ) bus ();

  packet_transmitter #(
    .FLIT_SIZE(FLIT), .NODE_ADDR(NODE), .CREDITS(CREDITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLeft    = 0;
    mHdrSent = 0;
    mHdr     = '0;
    mFlit    = '0;
    mValid   = 0;
    mErr     = 0;
    mCred    = CREDITS;
    mSent    = 0;
  endtask

  // Everything the design must show while reset is held
  task automatic checkReset();
    checkOutput("rst_valid",     64'(bus.out_flit_valid), 64'd0);
    checkOutput("rst_flit",      bus.out_flit,            64'd0);
    checkOutput("rst_credits",   64'(bus.credits),        64'(CREDITS));
    checkOutput("rst_sent",      64'(bus.packets_sent),   64'd0);
    checkOutput("rst_err",       64'(bus.err_len),        64'd0);
    checkOutput("rst_busy",      64'(bus.busy),           64'd0);
    checkOutput("rst_req_ready", 64'(bus.req_ready),      64'd0);
    checkOutput("rst_pay_ready", 64'(bus.payload_ready),  64'd0);
  endtask

  // Apply one cycle of inputs (called just after a rising edge), check the
  // combinational handshakes mid-cycle, advance the model over the edge and
  // check the registered outputs just after it.
  task automatic applyStimulus(input bit rv, input logic [7:0] to,
                               input logic [7:0] n, input bit pv,
                               input logic [63:0] pd, input bit cr);
    bit          emit;
    logic [63:0] val;
    bus.req_valid     = rv;
    bus.req_to_addr   = to;
    bus.req_n_body    = n;
    bus.payload_valid = pv;
    bus.payload       = pd;
    bus.credit_return = cr;
    @(negedge clk);
    checkOutput("req_ready", 64'(bus.req_ready), 64'(mLeft == 0));
    checkOutput("payload_ready", 64'(bus.payload_ready),
                64'(mLeft > 0 && mHdrSent && mCred > 0));
    emit = 0;
    val  = '0;
    mErr = 0;
    if (mLeft == 0) begin
      if (rv) begin
        if (int'(n) > 254) mErr = 1;
        else begin
          mLeft    = int'(n) + 1;
          mHdrSent = 0;
          mHdr     = (64'(to) << 56) | (64'(NODE) << 48) | (64'(int'(n) + 1) << 40);
        end
      end
    end else if (!mHdrSent) begin
      if (mCred > 0) begin
        emit = 1; val = mHdr; mHdrSent = 1; mLeft--;
      end
    end else if (pv && mCred > 0) begin
      emit = 1; val = pd; mLeft--;
    end
    if (emit && mLeft == 0) mSent = (mSent + 1) % 65536;
    if (emit && !cr) mCred--;
    else if (!emit && cr && mCred < CREDITS) mCred++;
    mValid = emit;
    if (emit) mFlit = val;
    @(posedge clk);
    #1;
    checkOutput("flit_valid", 64'(bus.out_flit_valid), 64'(mValid));
    checkOutput("flit",       bus.out_flit,            mFlit);
    checkOutput("credits",    64'(bus.credits),        64'(mCred));
    checkOutput("err_len",    64'(bus.err_len),        64'(mErr));
    checkOutput("sent",       64'(bus.packets_sent),   64'(mSent));
    checkOutput("busy",       64'(bus.busy),           64'(mLeft > 0));
  endtask

  task automatic idle(input int cycles, input bit cr);
    for (int i = 0; i < cycles; i++)
      applyStimulus(0, 8'h00, 8'h00, 0, 64'h0, cr);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [63:0] a;
    logic [63:0] b;
    bus.req_valid     = 0;
    bus.req_to_addr   = '0;
    bus.req_n_body    = '0;
    bus.payload       = '0;
    bus.payload_valid = 0;
    bus.credit_return = 0;
    rst = 1'b1;
    modelReset();
    #3;
    checkReset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] two-body packet to 0x05");
    a = 64'hA5A5_0000_1111_2222;
    b = 64'hB6B6_3333_4444_5555;
    applyStimulus(1, 8'h05, 8'd2, 0, 64'h0, 0);
    applyStimulus(0, 8'h00, 8'd0, 0, 64'h0, 0);
    checkOutput("t1_header", bus.out_flit, 64'h053C_0300_0000_0000);
    applyStimulus(0, 8'h00, 8'd0, 1, a, 0);
    applyStimulus(0, 8'h00, 8'd0, 1, b, 0);
    checkOutput("t1_last_body", bus.out_flit, b);
    checkOutput("t1_credits", 64'(bus.credits), 64'(CREDITS - 3));
    checkOutput("t1_sent", 64'(bus.packets_sent), 64'd1);

    $display("[TB] credit saturation and coincident return");
    idle(3, 1);
    idle(1, 1);
    checkOutput("t5_saturate", 64'(bus.credits), 64'(CREDITS));
    applyStimulus(1, 8'h11, 8'd1, 0, 64'h0, 0);
    applyStimulus(0, 8'h00, 8'd0, 0, 64'h0, 1);
    checkOutput("t5_coincident", 64'(bus.credits), 64'(CREDITS));
    applyStimulus(0, 8'h00, 8'd0, 1, rnd64(), 0);
    idle(1, 1);

    $display("[TB] credit stall with five-body packet");
    applyStimulus(1, 8'h22, 8'd5, 0, 64'h0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 8'd0, 1, rnd64(), 0);
    checkOutput("t2_stall_credits", 64'(bus.credits), 64'd0);
    checkOutput("t2_stall_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 8'h00, 8'd0, 1, rnd64(), 1);
      applyStimulus(0, 8'h00, 8'd0, 1, rnd64(), 0);
    end
    checkOutput("t2_done_credits", 64'(bus.credits), 64'd0);
    checkOutput("t2_done_busy", 64'(bus.busy), 64'd0);
    idle(4, 1);

    $display("[TB] header-only packet");
    applyStimulus(1, 8'h7E, 8'd0, 0, 64'h0, 0);
    applyStimulus(0, 8'h00, 8'd0, 0, 64'h0, 0);
    checkOutput("t3_header", bus.out_flit, 64'h7E3C_0100_0000_0000);
    idle(1, 1);

    $display("[TB] over-length request");
    applyStimulus(1, 8'h33, 8'd255, 0, 64'h0, 0);
    checkOutput("t4_err", 64'(bus.err_len), 64'd1);
    idle(2, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      logic [7:0] n;
      n = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      applyStimulus($urandom_range(0, 2) == 0, 8'($urandom), n,
                    $urandom_range(0, 3) != 0, rnd64(),
                    $urandom_range(0, 2) == 0);
    end
    while (mLeft > 0 && checks < 20000) applyStimulus(0, 8'h00, 8'd0, 1, rnd64(), 1);
    idle(4, 1);

    $display("[TB] reset mid-body of a maximum-length packet");
    applyStimulus(1, 8'h44, 8'd254, 0, 64'h0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 8'd0, 1, rnd64(), 1);
    checkOutput("t6_in_body", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    modelReset();
    checkReset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t6_hold_valid", 64'(bus.out_flit_valid), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 8'h55, 8'd1, 0, 64'h0, 0);
    applyStimulus(0, 8'h00, 8'd0, 0, 64'h0, 0);
    applyStimulus(0, 8'h00, 8'd0, 1, rnd64(), 0);
    idle(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
